fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 29 ++
 rtl/br_target_calc.sv | 27 ++
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage and its helpers.
package cpu_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  // Branch immediate field bounds inside the instruction word.
  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;
  localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;
  localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  // Sequential PC increment (one 32-bit instruction).
  localparam addr_t PC_INC = 64'd4;

  // Source selected for the next PC.
  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BR_REL = 2'd1,
    NPC_BR_REG = 2'd2
  } npc_sel_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic   stall;
  logic   BrTaken;
  logic   UncondBr;
  logic   BrReg;
  addr_t  br_reg_addr;
  addr_t  imem_addr;
  instr_t imem_instr;
  instr_t id_instr;
  addr_t  id_pc;
  addr_t  id_pc_plus4;
  logic   id_valid;

  // Fetch stage side.
  modport master (
    input  stall, BrTaken, UncondBr, BrReg, br_reg_addr, imem_instr,
    output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid
  );

  // Control, memory and decode side.
  modport slave (
    output stall, BrTaken, UncondBr, BrReg, br_reg_addr, imem_instr,
    input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid
  );

endinterface

// File: rtl/br_target_calc.sv
// PC-relative branch target: id_pc + (sign-extended imm26/imm19 << 2), wrapping mod 2^64.
module br_target_calc
  import cpu_pkg::*;
(
  input  addr_t  id_pc_i,
  input  instr_t id_instr_i,
  input  logic   uncond_br_i,
  output addr_t  target_o
);

  addr_t imm26_sext;
  addr_t imm19_sext;
  addr_t offset;

  // Opcode and register fields do not take part in the target.
  logic unused_fields;
  assign unused_fields = ^{id_instr_i[INSTR_W-1:IMM26_MSB+1], id_instr_i[IMM19_LSB-1:0]};

  // Sign-extend the selected offset, scale to bytes, add to the branch's own address.
  always_comb begin
    imm26_sext = {{(ADDR_W-IMM26_W){id_instr_i[IMM26_MSB]}}, id_instr_i[IMM26_MSB:IMM26_LSB]};
    imm19_sext = {{(ADDR_W-IMM19_W){id_instr_i[IMM19_MSB]}}, id_instr_i[IMM19_MSB:IMM19_LSB]};
    offset     = uncond_br_i ? imm26_sext : imm19_sext;
    target_o   = id_pc_i + (offset << 2);
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection with one delay slot, IF/ID pipeline register.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  addr_t    pc_q,          pc_d;
  instr_t   id_instr_q,    id_instr_d;
  addr_t    id_pc_q,       id_pc_d;
  addr_t    id_pc_plus4_q, id_pc_plus4_d;
  logic     id_valid_q,    id_valid_d;

  addr_t    br_target;
  addr_t    next_pc;
  npc_sel_e npc_sel;

  br_target_calc u_br_target_calc (
    .id_pc_i     (id_pc_q),
    .id_instr_i  (id_instr_q),
    .uncond_br_i (bus.UncondBr),
    .target_o    (br_target)
  );

  // A branch only counts when ID holds a real instruction; BrReg beats the relative target.
  always_comb begin
    npc_sel = NPC_SEQ;
    if (bus.BrTaken && id_valid_q) begin
      npc_sel = bus.BrReg ? NPC_BR_REG : NPC_BR_REL;
    end
  end

  // Map the selection to an address; register targets pass through unaligned.
  always_comb begin
    unique case (npc_sel)
      NPC_BR_REG: next_pc = bus.br_reg_addr;
      NPC_BR_REL: next_pc = br_target;
      default:    next_pc = pc_q + PC_INC;
    endcase
  end

  // Advance PC and IF/ID on every unstalled cycle; the fetched word is the delay slot.
  always_comb begin
    // NOTE: every _d gets its hold value first, so the stall path needs no else and no latch is inferred.
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    if (!bus.stall) begin
      pc_d          = next_pc;
      id_instr_d    = bus.imem_instr;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_q + PC_INC;
      id_valid_d    = 1'b1;
    end
  end

  // State registers; synchronous reset overrides stall and any pending branch.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    if (reset) begin
      pc_q          <= '0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_valid_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.id_valid    = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: directed scenarios plus randomized control against a behavioural model.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Instruction memory: explicit words override a per-address default pattern.
  instr_t prog[addr_t];
  bit     mem_hash = 1'b0;

  // Architectural model state.
  addr_t  m_pc;
  addr_t  m_ipc;
  addr_t  m_ipc4;
  instr_t m_ins;
  bit     m_v;

  function automatic instr_t mem_rd(addr_t a);
    if (prog.exists(a)) return prog[a];
    if (mem_hash) return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
    return 32'h9100_0000 | a[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock of the fetch stage as the architecture describes it.
  task automatic model_step(input bit rst, input bit st, input bit bt, input bit ub,
                            input bit br, input addr_t bra);
    longint off;
    addr_t  nxt;
    if (rst) begin
      m_pc = '0; m_ipc = '0; m_ipc4 = '0; m_ins = '0; m_v = 1'b0;
    end else if (!st) begin
      if (bt && m_v && br) begin
        nxt = bra;
      end else if (bt && m_v) begin
        off = ub ? longint'($signed(m_ins[25:0])) : longint'($signed(m_ins[23:5]));
        nxt = m_ipc + addr_t'(off * 64'sd4);
      end else begin
        nxt = m_pc + 64'd4;
      end
      m_ins  = mem_rd(m_pc);
      m_ipc  = m_pc;
      m_ipc4 = m_pc + 64'd4;
      m_v    = 1'b1;
      m_pc   = nxt;
    end
  endtask

  // Drive one cycle from a negedge, then compare every output to the model at the next negedge.
  task automatic step(input bit rst, input bit st, input bit bt, input bit ub,
                      input bit br, input addr_t bra);
    reset           = rst;
    bus.stall       = st;
    bus.BrTaken     = bt;
    bus.UncondBr    = ub;
    bus.BrReg       = br;
    bus.br_reg_addr = bra;
    bus.imem_instr  = mem_rd(bus.imem_addr);
    @(posedge clk);
    model_step(rst, st, bt, ub, br, bra);
    @(negedge clk);
    cyc++;
    check("m_imem_addr", bus.imem_addr, m_pc);
    check("m_id_instr", bus.id_instr, m_ins);
    check("m_id_pc", bus.id_pc, m_ipc);
    check("m_id_pc_plus4", bus.id_pc_plus4, m_ipc4);
    check("m_id_valid", bus.id_valid, m_v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    bus.stall       = 1'b0;
    bus.BrTaken     = 1'b0;
    bus.UncondBr    = 1'b0;
    bus.BrReg       = 1'b0;
    bus.br_reg_addr = '0;
    bus.imem_instr  = '0;
    @(negedge clk);

    // Reset, then free-running sequential fetch.
    step(1, 0, 0, 0, 0, 0);
    check("rst_imem_addr", bus.imem_addr, 64'd0);
    check("rst_id_valid", bus.id_valid, 1'b0);
    check("rst_id_pc", bus.id_pc, 64'd0);
    prog[64'h8]  = 32'h1400_0003;
    prog[64'h20] = 32'hB4FF_FFC0;
    step(0, 0, 0, 0, 0, 0);
    check("seq1_imem_addr", bus.imem_addr, 64'd4);
    check("seq1_id_pc", bus.id_pc, 64'd0);
    check("seq1_id_valid", bus.id_valid, 1'b1);
    check("seq1_id_instr", bus.id_instr, 32'h9100_0000);
    step(0, 0, 0, 0, 0, 0);
    check("seq2_imem_addr", bus.imem_addr, 64'd8);
    check("seq2_id_pc", bus.id_pc, 64'd4);
    step(0, 0, 0, 0, 0, 0);
    check("seq3_imem_addr", bus.imem_addr, 64'd12);
    check("seq3_id_pc", bus.id_pc, 64'd8);
    check("b_in_id", bus.id_instr, 32'h1400_0003);

    // Unconditional B at 8: delay slot at 12 enters ID, fetch continues at 0x14.
    step(0, 0, 1, 1, 0, 0);
    check("b_delay_slot_pc", bus.id_pc, 64'd12);
    check("b_delay_slot_instr", bus.id_instr, 32'h9100_000C);
    check("b_target", bus.imem_addr, 64'h14);

    // Walk to the CBZ at 0x20.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    check("cbz_id_pc", bus.id_pc, 64'h20);
    check("cbz_id_instr", bus.id_instr, 32'hB4FF_FFC0);
    check("cbz_link", bus.id_pc_plus4, 64'h24);
    step(0, 0, 1, 0, 0, 0);
    check("cbz_target", bus.imem_addr, 64'h18);
    check("cbz_slot_pc", bus.id_pc, 64'h24);

    // BR in ID with stall: everything holds, branch taken on the first unstalled edge.
    step(0, 0, 0, 0, 0, 0);
    check("br_id_pc", bus.id_pc, 64'h18);
    step(0, 1, 1, 0, 1, 64'h100);
    check("stall_imem_addr", bus.imem_addr, 64'h1C);
    check("stall_id_pc", bus.id_pc, 64'h18);
    check("stall_id_pc_plus4", bus.id_pc_plus4, 64'h1C);
    check("stall_id_instr", bus.id_instr, 32'h9100_0018);
    step(0, 1, 1, 0, 1, 64'h100);
    check("stall2_imem_addr", bus.imem_addr, 64'h1C);
    step(0, 0, 1, 0, 1, 64'h100);
    check("br_target", bus.imem_addr, 64'h100);
    check("br_slot_pc", bus.id_pc, 64'h1C);

    // BrReg alone has no effect; register target keeps its low bits.
    step(0, 0, 0, 0, 1, 64'h500);
    check("brreg_no_taken", bus.imem_addr, 64'h104);
    step(0, 0, 1, 0, 1, 64'h203);
    check("br_unaligned", bus.imem_addr, 64'h203);

    // PC wrap at the top of the address space, then backwards B from id_pc 0.
    prog[64'h0] = 32'h17FF_FFFF;
    step(0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    check("br_top_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, 0, 0);
    check("wrap_imem_addr", bus.imem_addr, 64'd0);
    check("wrap_link", bus.id_pc_plus4, 64'd0);
    step(0, 0, 0, 0, 0, 0);
    check("b_neg_id_pc", bus.id_pc, 64'd0);
    step(0, 0, 1, 1, 0, 0);
    check("b_neg_target", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // Reset beats stall and BrTaken; a branch with id_valid low is ignored.
    step(1, 1, 1, 0, 1, 64'h500);
    check("rst_ovr_imem_addr", bus.imem_addr, 64'd0);
    check("rst_ovr_id_instr", bus.id_instr, 32'd0);
    check("rst_ovr_id_pc", bus.id_pc, 64'd0);
    check("rst_ovr_id_pc_plus4", bus.id_pc_plus4, 64'd0);
    check("rst_ovr_id_valid", bus.id_valid, 1'b0);
    step(0, 0, 1, 0, 1, 64'h500);
    check("invalid_br_ignored", bus.imem_addr, 64'd4);
    check("first_fetch_pc", bus.id_pc, 64'd0);
    check("first_fetch_instr", bus.id_instr, 32'h17FF_FFFF);

    // Randomized control against the model.
    prog.delete();
    mem_hash = 1'b1;
    for (int i = 0; i < 400; i++) begin
      addr_t bra;
      bra = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) bra = {32'd0, 16'd0, bra[15:0]};
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           1'($urandom),
           $urandom_range(0, 3) == 0,
           bra);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
